// File: rtl/ifmap_pkg.sv
// ============================================================================
// Package  : ifmap_pkg
// Brief    : Packet layout, opcodes and FSM state type shared by the PPE
//            ifmap requester and its row FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifmap_pkg;

    localparam int PKT_W     = 33;
    localparam int ADDR_HI   = 32;
    localparam int ADDR_LO   = 29;
    localparam int OPCODE_HI = 28;
    localparam int OPCODE_LO = 25;
    localparam int DATA_HI   = 24;
    localparam int DATA_LO   = 0;

    localparam logic [3:0] OP_WEIGHTS_DONE    = 4'd0;
    localparam logic [3:0] OP_PPE_INPUT       = 4'd1;
    localparam logic [3:0] OP_PPE_5_REQ_INPUT = 4'd5;
    localparam logic [3:0] OP_PPE_6_REQ_INPUT = 4'd6;
    localparam logic [3:0] OP_PPE_7_REQ_INPUT = 4'd7;
    localparam logic [3:0] OP_PPE_8_REQ_INPUT = 4'd8;
    localparam logic [3:0] OP_PPE_9_REQ_INPUT = 4'd9;
    localparam logic [3:0] OP_TIMESTEP_DONE   = 4'd10;

    localparam logic [3:0] IMEM_ID = 4'd10;

    typedef struct packed {
        logic [ADDR_HI-ADDR_LO:0]     dest;
        logic [OPCODE_HI-OPCODE_LO:0] opcode;
        logic [DATA_HI-DATA_LO:0]     data;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ifmap_row_fifo.sv
// ============================================================================
// Module   : ifmap_row_fifo
// Brief    : Small synchronous FIFO; a push and a pop in the same cycle are
//            both honoured, even when full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifmap_row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ppe_ifmap_requester.sv
// ============================================================================
// Module   : ppe_ifmap_requester
// Brief    : PPE input front end: requests ifmap rows from IMEM, buffers the
//            replies and hands them to the PE datapath.
// Options  : IFMAP_REQ_ERRCNT_EN adds err_cnt, a saturating dropped-packet count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppe_ifmap_requester
    import ifmap_pkg::*;
#(
    parameter int PE_ID       = 5,
    parameter int IMEM_ID     = 10,
    parameter int ROW_W       = 25,
    parameter int ROWS_PER_TS = 5,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ts_start,
    input  logic              pkt_in_valid,
    output logic              pkt_in_ready,
    input  logic [32:0]       pkt_in_data,
    output logic              pkt_out_valid,
    input  logic              pkt_out_ready,
    output logic [32:0]       pkt_out_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [ROW_W-1:0]  row_data,
    output logic              row_last,
    output logic              ts_done
`ifdef IFMAP_REQ_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int              ENT_W      = ROW_W + 3;
    localparam logic [2:0]      c_rows     = 3'(ROWS_PER_TS);
    localparam logic [2:0]      c_last_idx = 3'(ROWS_PER_TS - 1);
    localparam logic [CNT_W:0]  c_depth    = (CNT_W+1)'(FIFO_DEPTH);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_req_cnt;
    logic [2:0]       r_rcv_cnt;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_req_valid;
    pkt_t             r_req_pkt;

    pkt_t             w_pkt_in;
    logic             w_in_hs, w_row_good, w_push, w_out_hs, w_pop;
    logic             w_arm, w_issue;
    logic             w_full, w_empty;
    logic [CNT_W-1:0] w_occ;
    logic [CNT_W:0]   w_budget;
    logic [ENT_W-1:0] w_head;

    assign w_pkt_in     = pkt_t'(pkt_in_data);
    assign pkt_in_ready = !w_full;
    assign w_in_hs      = pkt_in_valid && !w_full;
    // Outstanding is zero in IDLE and after reset, so stale replies fall through as drops.
    assign w_row_good   = (r_state != ST_IDLE) && (w_pkt_in.dest == 4'(PE_ID)) &&
                          (w_pkt_in.opcode == OP_PPE_INPUT) && (r_outstanding != '0);
    assign w_push       = w_in_hs && w_row_good;
    assign w_out_hs     = r_req_valid && pkt_out_ready;
    assign w_pop        = !w_empty && row_ready;
    assign w_budget     = {1'b0, w_occ} + {1'b0, r_outstanding};

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ts_start) begin
                    w_arm       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (r_req_cnt >= c_rows) begin
                    w_state_nxt = ST_DRAIN;
                end else if (!r_req_valid && (w_budget < c_depth)) begin
                    w_issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if ((r_rcv_cnt >= c_rows) && w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_cnt     <= '0;
            r_rcv_cnt     <= '0;
            r_outstanding <= '0;
            r_req_valid   <= 1'b0;
            r_req_pkt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm) begin
                // The unsolicited broadcast row stands in for request 0.
                r_req_cnt     <= 3'd1;
                r_rcv_cnt     <= 3'd0;
                r_outstanding <= CNT_W'(1);
            end else begin
                if (w_out_hs && (r_req_cnt < c_rows)) begin
                    r_req_cnt <= r_req_cnt + 3'd1;
                end
                if (w_push && (r_rcv_cnt < c_rows)) begin
                    r_rcv_cnt <= r_rcv_cnt + 3'd1;
                end
                r_outstanding <= r_outstanding + CNT_W'(w_out_hs) - CNT_W'(w_push);
            end
            if (w_issue) begin
                r_req_valid <= 1'b1;
                r_req_pkt   <= '{dest: 4'(IMEM_ID), opcode: 4'(PE_ID), data: 25'(r_req_cnt)};
            end else if (w_out_hs) begin
                r_req_valid <= 1'b0;
            end
        end
    end

    // Each entry carries its row index so row_last needs no separate counter.
    ifmap_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_row_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({r_rcv_cnt, w_pkt_in.data[ROW_W-1:0]}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_occ)
    );

    assign pkt_out_valid = r_req_valid;
    assign pkt_out_data  = r_req_pkt;
    assign row_valid     = !w_empty;
    assign row_data      = w_head[ROW_W-1:0];
    assign row_last      = !w_empty && (w_head[ENT_W-1:ROW_W] == c_last_idx);
    assign ts_done       = (r_state == ST_DONE);

`ifdef IFMAP_REQ_ERRCNT_EN
    logic       w_drop;
    logic [7:0] r_err_cnt;

    assign w_drop = w_in_hs && !w_row_good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_drop && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ppe_ifmap_requester.sv
// ============================================================================
// Module   : tb_ppe_ifmap_requester
// Brief    : Self-checking bench; a router/IMEM model answers requests with
//            random rows and delays, and a row queue predicts the datapath side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppe_ifmap_requester;

    localparam int         ROWS  = 5;
    localparam int         DEPTH = 2;
    localparam logic [3:0] PE    = 4'd5;
    localparam logic [3:0] IMEM  = 4'd10;
    localparam logic [3:0] OP_IN = 4'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ts_start = 1'b0;
    logic        pkt_in_valid = 1'b0;
    logic        pkt_in_ready;
    logic [32:0] pkt_in_data = '0;
    logic        pkt_out_valid;
    logic        pkt_out_ready = 1'b0;
    logic [32:0] pkt_out_data;
    logic        row_valid;
    logic        row_ready = 1'b0;
    logic [24:0] row_data;
    logic        row_last;
    logic        ts_done;
`ifdef IFMAP_REQ_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ppe_ifmap_requester #(
        .PE_ID       (5),
        .IMEM_ID     (10),
        .ROW_W       (25),
        .ROWS_PER_TS (ROWS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ts_start      (ts_start),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in_ready  (pkt_in_ready),
        .pkt_in_data   (pkt_in_data),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out_ready (pkt_out_ready),
        .pkt_out_data  (pkt_out_data),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .row_data      (row_data),
        .row_last      (row_last),
        .ts_done       (ts_done)
`ifdef IFMAP_REQ_ERRCNT_EN
        ,
        .err_cnt       (err_cnt)
`endif
    );

    // Request packet the IMEM expects for row index idx.
    function automatic logic [32:0] req_pkt(input int idx);
        return {IMEM, PE, 25'(idx)};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ts_start = 1'b0; pkt_in_valid = 1'b0; pkt_in_data = '0;
        pkt_out_ready = 1'b0; row_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_ts();
        ts_start = 1'b1;
        @(negedge clk);
        ts_start = 1'b0;
    endtask

    // Drives one packet and returns on the negedge after it was accepted.
    task automatic send_pkt(input logic [3:0] d, input logic [3:0] op, input logic [24:0] data);
        int n = 0;
        pkt_in_data  = {d, op, data};
        pkt_in_valid = 1'b1;
        while (!pkt_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!pkt_in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: pkt_in_ready=%b required 1 within 50 cycles", pkt_in_ready);
        end
        @(negedge clk);
        pkt_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({pkt_out_valid, pkt_out_data, row_valid, row_data, row_last, ts_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: out_v=%b out_d=%h row_v=%b row_d=%h last=%b done=%b required all 0",
                     pkt_out_valid, pkt_out_data, row_valid, row_data, row_last, ts_done);
        end
        checks++;
        if (pkt_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", pkt_in_ready);
        end
`ifdef IFMAP_REQ_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
        end
`endif
    endtask

    task automatic test_first_row();
        int n = 0;
        apply_reset();
        pulse_ts();
        send_pkt(PE, OP_IN, 25'h1ABCDEF);
        checks++;
        if (row_valid !== 1'b1 || row_data !== 25'h1ABCDEF || row_last !== 1'b0) begin
            errors++;
            $display("FAIL first_row: valid=%b data=%h last=%b required 1 1abcdef 0", row_valid, row_data, row_last);
        end
        while (!pkt_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pkt_out_valid !== 1'b1 || pkt_out_data !== req_pkt(1)) begin
            errors++;
            $display("FAIL first_req: valid=%b data=%h required 1 %h", pkt_out_valid, pkt_out_data, req_pkt(1));
        end
    endtask

    task automatic test_timestep(input int row_pct);
        int          owed, next_req, reqs, pops, pulses, after, cyc;
        logic [24:0] q[$];
        logic        prev_valid, prev_hs, out_hs;
        logic [32:0] prev_data;
        logic [24:0] d;
        pulse_ts();
        owed = 1; next_req = 1; reqs = 0; pops = 0; pulses = 0; after = 0; cyc = 0;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
        while (after < 6 && cyc < 3000) begin
            if (prev_valid && !prev_hs) begin
                checks++;
                if (pkt_out_valid !== 1'b1 || pkt_out_data !== prev_data) begin
                    errors++;
                    $display("FAIL req_hold: valid=%b data=%h required 1 %h", pkt_out_valid, pkt_out_data, prev_data);
                end
            end
            if (ts_done === 1'b1) begin
                pulses++;
                checks++;
                if (pops != ROWS) begin
                    errors++;
                    $display("FAIL ts_done_early: rows consumed=%0d required %0d", pops, ROWS);
                end
            end
            if (pops == ROWS) after++;
            pkt_out_ready = ($urandom_range(0, 99) < 60);
            row_ready     = ($urandom_range(0, 99) < row_pct);
            d             = 25'($urandom);
            pkt_in_valid  = (owed > 0) && ($urandom_range(0, 99) < 70);
            pkt_in_data   = {PE, OP_IN, d};
            // Stray pulses mid-timestep must be ignored.
            ts_start      = (pops < ROWS) && ($urandom_range(0, 19) == 0);
            out_hs        = pkt_out_valid && pkt_out_ready;
            if (out_hs) begin
                checks++;
                if (next_req >= ROWS || pkt_out_data !== req_pkt(next_req)) begin
                    errors++;
                    $display("FAIL req_data: got %h required %h (request #%0d of %0d)",
                             pkt_out_data, req_pkt(next_req), next_req, ROWS - 1);
                end
                checks++;
                if (2 + reqs - pops > DEPTH) begin
                    errors++;
                    $display("FAIL credit: rows granted minus consumed=%0d required <= %0d", 2 + reqs - pops, DEPTH);
                end
                reqs++; next_req++; owed++;
            end
            if (row_valid && row_ready) begin
                checks++;
                if (q.size() == 0 || row_data !== q[0] || row_last !== (pops == ROWS - 1)) begin
                    errors++;
                    $display("FAIL row_out: data=%h last=%b required %h last=%b (queued=%0d)",
                             row_data, row_last, (q.size() > 0) ? q[0] : 25'h0, (pops == ROWS - 1), q.size());
                end
                if (q.size() > 0) void'(q.pop_front());
                pops++;
            end
            if (pkt_in_valid && pkt_in_ready) begin
                q.push_back(d);
                owed--;
            end
            prev_valid = pkt_out_valid; prev_hs = out_hs; prev_data = pkt_out_data;
            @(negedge clk);
            cyc++;
        end
        ts_start = 1'b0; pkt_in_valid = 1'b0; pkt_out_ready = 1'b0; row_ready = 1'b0;
        checks++;
        if (reqs != ROWS - 1 || pops != ROWS) begin
            errors++;
            $display("FAIL ts_counts: requests=%0d rows=%0d required %0d %0d", reqs, pops, ROWS - 1, ROWS);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ts_done_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_backpressure();
        int          n = 0;
        logic        saw_req = 1'b0;
        logic [24:0] a, b;
        a = 25'($urandom);
        b = 25'($urandom);
        apply_reset();
        pkt_out_ready = 1'b1;
        pulse_ts();
        send_pkt(PE, OP_IN, a);
        while (!pkt_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pkt_out_data !== req_pkt(1)) begin
            errors++;
            $display("FAIL bp_req1: got %h required %h", pkt_out_data, req_pkt(1));
        end
        @(negedge clk);
        send_pkt(PE, OP_IN, b);
        repeat (10) begin
            if (pkt_out_valid) saw_req = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_req !== 1'b0 || pkt_in_ready !== 1'b0 || row_valid !== 1'b1 || row_data !== a) begin
            errors++;
            $display("FAIL bp_full: saw_req=%b in_ready=%b row_v=%b row_d=%h required 0 0 1 %h",
                     saw_req, pkt_in_ready, row_valid, row_data, a);
        end
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
        checks++;
        if (row_valid !== 1'b1 || row_data !== b) begin
            errors++;
            $display("FAIL bp_pop: row_v=%b row_d=%h required 1 %h", row_valid, row_data, b);
        end
        n = 0;
        while (!pkt_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pkt_out_valid !== 1'b1 || pkt_out_data !== req_pkt(2)) begin
            errors++;
            $display("FAIL bp_req2: valid=%b data=%h required 1 %h", pkt_out_valid, pkt_out_data, req_pkt(2));
        end
        pkt_out_ready = 1'b0;
    endtask

    task automatic test_drop();
        logic [24:0] d3;
        d3 = 25'($urandom);
        apply_reset();
        pulse_ts();
        send_pkt(4'd6, OP_IN, 25'($urandom));
        send_pkt(PE, 4'd0, 25'($urandom));
        checks++;
        if (row_valid !== 1'b0 || pkt_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_fifo: row_v=%b in_ready=%b required 0 1", row_valid, pkt_in_ready);
        end
`ifdef IFMAP_REQ_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL drop_err_cnt: got %0d required 2", err_cnt);
        end
`endif
        send_pkt(PE, OP_IN, d3);
        checks++;
        if (row_valid !== 1'b1 || row_data !== d3) begin
            errors++;
            $display("FAIL drop_then_good: row_v=%b row_d=%h required 1 %h", row_valid, row_data, d3);
        end
    endtask

    task automatic test_stall_reset();
        int   n = 0;
        logic held = 1'b1;
        apply_reset();
        pulse_ts();
        while (!pkt_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pkt_out_valid !== 1'b1 || pkt_out_data !== req_pkt(1)) begin
            errors++;
            $display("FAIL stall_req: valid=%b data=%h required 1 %h", pkt_out_valid, pkt_out_data, req_pkt(1));
        end
        repeat (10) begin
            if (pkt_out_valid !== 1'b1 || pkt_out_data !== req_pkt(1)) held = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: held=%b required 1 (data now %h)", held, pkt_out_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pkt_out_valid, pkt_out_data, row_valid, row_data, row_last, ts_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: out_v=%b out_d=%h row_v=%b required all 0", pkt_out_valid, pkt_out_data, row_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        send_pkt(PE, OP_IN, 25'($urandom));
        repeat (2) @(negedge clk);
        checks++;
        if ({pkt_out_valid, pkt_out_data, row_valid, row_data, row_last, ts_done} !== '0) begin
            errors++;
            $display("FAIL stale_reply: out_v=%b out_d=%h row_v=%b row_d=%h required all 0",
                     pkt_out_valid, pkt_out_data, row_valid, row_data);
        end
`ifdef IFMAP_REQ_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL stale_err_cnt: got %0d required 1", err_cnt);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_row();
        apply_reset();
        test_timestep(100);
        test_timestep(40);
        test_timestep(15);
        test_backpressure();
        test_drop();
        test_stall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
